// File: rtl/fp_pkg.sv
// Shared binary32 field layout, constants and classification helpers for the FP adder.
package fp_pkg;
  localparam int          EXP_W  = 8;
  localparam int          FRAC_W = 23;
  localparam int          BIAS   = 127;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == 8'hFF) && (x.frac != 23'd0);
  endfunction

  function automatic logic is_inf(input fp32_t x);
    return (x.exp == 8'hFF) && (x.frac == 23'd0);
  endfunction

  // Subnormals have exp==0 and are flushed, so they classify as zero.
  function automatic logic is_zero(input fp32_t x);
    return (x.exp == 8'h00);
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [26:0] data_i,
  output logic [4:0]  count_o
);

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    count_o = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (data_i[i]) begin
        count_o = 5'(26 - i);
      end else begin
        count_o = count_o;
      end
    end
  end

endmodule

// File: rtl/fp_add_sub.sv
// Single-precision add/subtract: combinational align/add/normalise/round into one output register.
module fp_add_sub
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signal,
  input  logic [31:0] a_fpn,
  input  logic [31:0] b_fpn,
  output logic [31:0] out
);

  fp32_t       a_s, b_s;
  logic        sb_eff_s, eff_sub_s, a_big_s, big_sign_s;
  logic [7:0]  big_exp_s, sm_exp_s, d_s;
  logic [22:0] big_frac_s, sm_frac_s;
  logic [26:0] ma_s, mb_s, mb_al_s, diff_s, m_s;
  logic [53:0] wide_s;
  logic [27:0] sum_s;
  logic [4:0]  lz_s;
  logic signed [9:0] exp_s;
  logic        rnd_s;
  logic [24:0] mant_s;
  logic [22:0] frac_s;
  logic [31:0] res_d, out_q;

  // Order operands by magnitude and align the smaller mantissa with guard/round/sticky.
  always_comb begin
    a_s       = a_fpn;
    b_s       = b_fpn;
    sb_eff_s  = b_s.sign ^ ~signal;
    eff_sub_s = a_s.sign ^ sb_eff_s;
    a_big_s   = {a_s.exp, a_s.frac} >= {b_s.exp, b_s.frac};
    if (a_big_s) begin
      big_sign_s = a_s.sign;
      big_exp_s  = a_s.exp;
      big_frac_s = a_s.frac;
      sm_exp_s   = b_s.exp;
      sm_frac_s  = b_s.frac;
    end else begin
      big_sign_s = sb_eff_s;
      big_exp_s  = b_s.exp;
      big_frac_s = b_s.frac;
      sm_exp_s   = a_s.exp;
      sm_frac_s  = a_s.frac;
    end
    d_s    = big_exp_s - sm_exp_s;
    ma_s   = {1'b1, big_frac_s, 3'b000};
    mb_s   = {1'b1, sm_frac_s, 3'b000};
    wide_s = {mb_s, 27'd0} >> d_s;
    if (d_s >= 8'd26) begin
      mb_al_s = 27'd1;
    end else begin
      mb_al_s = {wide_s[53:28], wide_s[27] | (|wide_s[26:0])};
    end
    sum_s  = {1'b0, ma_s} + {1'b0, mb_al_s};
    diff_s = ma_s - mb_al_s;
  end

  fp_lzc u_lzc (
    .data_i  (diff_s),
    .count_o (lz_s)
  );

  // Special-case selection, then normalise, round to nearest even and range-check.
  always_comb begin
    m_s    = sum_s[26:0];
    exp_s  = $signed({2'b00, big_exp_s});
    rnd_s  = 1'b0;
    mant_s = 25'd0;
    frac_s = 23'd0;
    res_d  = 32'h0000_0000;
    if (is_nan(a_s) || is_nan(b_s)) begin
      res_d = QNAN;
    end else if (is_inf(a_s) && is_inf(b_s)) begin
      res_d = eff_sub_s ? QNAN : {a_s.sign, 8'hFF, 23'd0};
    end else if (is_inf(a_s)) begin
      res_d = {a_s.sign, 8'hFF, 23'd0};
    end else if (is_inf(b_s)) begin
      res_d = {sb_eff_s, 8'hFF, 23'd0};
    end else if (is_zero(a_s) && is_zero(b_s)) begin
      res_d = {a_s.sign & sb_eff_s, 31'd0};
    end else if (is_zero(a_s)) begin
      res_d = {sb_eff_s, b_s.exp, b_s.frac};
    end else if (is_zero(b_s)) begin
      res_d = a_s;
    end else begin
      if (!eff_sub_s) begin
        if (sum_s[27]) begin
          m_s   = {sum_s[27:2], sum_s[1] | sum_s[0]};
          exp_s = exp_s + 10'sd1;
        end else begin
          m_s = sum_s[26:0];
        end
      end else begin
        m_s   = diff_s << lz_s;
        exp_s = exp_s - $signed({5'd0, lz_s});
      end
      rnd_s  = m_s[2] & (m_s[1] | m_s[0] | m_s[3]);
      mant_s = {1'b0, m_s[26:3]} + {24'd0, rnd_s};
      if (mant_s[24]) begin
        exp_s  = exp_s + 10'sd1;
        frac_s = mant_s[23:1];
      end else begin
        frac_s = mant_s[22:0];
      end
      if (eff_sub_s && (diff_s == 27'd0)) begin
        res_d = 32'h0000_0000;
      end else if (exp_s <= 10'sd0) begin
        res_d = {big_sign_s, 31'd0};
      end else if (exp_s >= 10'sd255) begin
        res_d = {big_sign_s, 8'hFF, 23'd0};
      end else begin
        res_d = {big_sign_s, exp_s[7:0], frac_s};
      end
    end
  end

  // Output register, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= 32'h0000_0000;
    end else begin
      out_q <= res_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_fp_add_sub.sv
// Directed-vector bench for fp_add_sub with hand-computed binary32 results.
module tb_fp_add_sub;
  logic        clk;
  logic        rst;
  logic        signal;
  logic [31:0] a_fpn;
  logic [31:0] b_fpn;
  logic [31:0] out;
  logic [31:0] prev_exp;
  int          checks;
  int          errors;

  fp_add_sub dut (
    .clk    (clk),
    .rst    (rst),
    .signal (signal),
    .a_fpn  (a_fpn),
    .b_fpn  (b_fpn),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive new operands just after an edge; out must hold until the next edge, then update.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [31:0] exp, input string tag);
    a_fpn  = a;
    b_fpn  = b;
    signal = op;
    #2;
    chk({tag, "_hold"}, out, prev_exp);
    @(posedge clk);
    #1;
    chk(tag, out, exp);
    prev_exp = exp;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    signal = 1'b1;
    a_fpn  = 32'h4120_0000;
    b_fpn  = 32'h4120_0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      a_fpn  = $urandom;
      b_fpn  = $urandom;
      signal = 1'($urandom_range(1, 0));
      chk("rst_hold", out, 32'h0000_0000);
    end
    a_fpn  = 32'h0000_0000;
    b_fpn  = 32'h0000_0000;
    signal = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_release", out, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("zero_plus_zero", out, 32'h0000_0000);
    prev_exp = 32'h0000_0000;

    step(32'h41A0_0000, 32'h42C8_0000, 1'b1, 32'h42F0_0000, "add_20_100");
    step(32'h41A0_0000, 32'h4000_0000, 1'b1, 32'h41B0_0000, "add_20_2");
    step(32'h4190_0000, 32'h4040_0000, 1'b1, 32'h41A8_0000, "add_18_3");
    step(32'h41A0_0000, 32'h4090_0000, 1'b0, 32'h4178_0000, "sub_20_4p5");
    step(32'hC1C8_0000, 32'hC1C8_0000, 1'b0, 32'h0000_0000, "sub_m25_m25");
    step(32'hC1C8_0000, 32'h4188_0000, 1'b1, 32'hC100_0000, "add_m25_17");
    step(32'h41A0_0000, 32'h42C8_0000, 1'b0, 32'hC2A0_0000, "sub_20_100");
    step(32'h3F80_0000, 32'h3F40_0000, 1'b0, 32'h3E80_0000, "sub_norm_left");
    step(32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7FC0_0000, "inf_minus_inf");
    step(32'h7FC1_2345, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, "nan_in");
    step(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h7F80_0000, "overflow");
    step(32'h3F80_0000, 32'h3080_0000, 1'b1, 32'h3F80_0000, "sticky_only");
    step(32'h3F80_0000, 32'h3380_0000, 1'b1, 32'h3F80_0000, "tie_even");
    step(32'h3F80_0001, 32'h3380_0000, 1'b1, 32'h3F80_0002, "tie_odd_up");
    step(32'h3F80_0000, 32'h7F80_0000, 1'b0, 32'hFF80_0000, "one_minus_inf");
    step(32'h0000_0000, 32'h4000_0000, 1'b0, 32'hC000_0000, "zero_minus_2");
    step(32'h4040_0000, 32'h0000_0000, 1'b1, 32'h4040_0000, "three_plus_zero");
    step(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, "negzero_sum");
    step(32'h00C0_0000, 32'h0080_0000, 1'b0, 32'h0000_0000, "underflow_flush");
    step(32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, "sub_3_1");

    a_fpn = 32'h41A0_0000;
    b_fpn = 32'h42C8_0000;
    signal = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_async_rst", out, 32'h42F0_0000);
    rst = 1'b0;
    #1;
    chk("async_rst", out, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_release", out, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("after_release", out, 32'h42F0_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
